// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector: shifts in one bit per qualified clock
// and pulses detect when the last WIDTH sampled bits equal PATTERN.
module seq_detect_param #(
  parameter int                 WIDTH   = 4,
  parameter logic [WIDTH-1:0]   PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         x_in,
  input  logic                         x_en,
  input  logic                         cnt_clr,
  output logic                         detect,
  output logic [WIDTH-1:0]             hist,
  output logic [$clog2(WIDTH+1)-1:0]   fill,
  output logic [CNT_W-1:0]             match_count
);

  localparam int FW = $clog2(WIDTH + 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("seq_detect_param: WIDTH=%0d outside legal range 2..32", WIDTH);
  end

  logic [WIDTH-1:0] nh;
  logic [FW-1:0]    nf;
  logic             hit;

  always_comb begin
    nh  = {hist[WIDTH-2:0], x_in};
    nf  = (fill == FW'(WIDTH)) ? fill : fill + 1'b1;
    // Partial history never matches, even if the zero-padded value equals PATTERN
    hit = x_en && (nh == PATTERN) && (nf == FW'(WIDTH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      detect      <= 1'b0;
      hist        <= '0;
      fill        <= '0;
      match_count <= '0;
    end else begin
      detect <= hit;
      if (x_en) begin
        hist <= nh;
        fill <= (hit && !OVERLAP) ? '0 : nf;
      end
      if (cnt_clr)
        match_count <= '0;
      else if (hit && match_count != '1)
        match_count <= match_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench: four detector variants share one stimulus stream; a
// reference model pushes expected outputs per edge, a checker pops them.
module tb_seq_detect_param;

  logic clock, reset, x_in, x_en, cnt_clr;

  logic       det_a, det_b, det_c, det_d;
  logic [3:0] hist_a, hist_b, hist_c, hist_d;
  logic [2:0] fill_a, fill_b, fill_c, fill_d;
  logic [7:0] cnt_a, cnt_b, cnt_d;
  logic [1:0] cnt_c;

  seq_detect_param #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_a (
    .clock(clock), .reset(reset), .x_in(x_in), .x_en(x_en), .cnt_clr(cnt_clr),
    .detect(det_a), .hist(hist_a), .fill(fill_a), .match_count(cnt_a));
  seq_detect_param #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_b (
    .clock(clock), .reset(reset), .x_in(x_in), .x_en(x_en), .cnt_clr(cnt_clr),
    .detect(det_b), .hist(hist_b), .fill(fill_b), .match_count(cnt_b));
  seq_detect_param #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_c (
    .clock(clock), .reset(reset), .x_in(x_in), .x_en(x_en), .cnt_clr(cnt_clr),
    .detect(det_c), .hist(hist_c), .fill(fill_c), .match_count(cnt_c));
  seq_detect_param #(.WIDTH(4), .PATTERN(4'b0001), .OVERLAP(1'b1), .CNT_W(8)) u_d (
    .clock(clock), .reset(reset), .x_in(x_in), .x_en(x_en), .cnt_clr(cnt_clr),
    .detect(det_d), .hist(hist_d), .fill(fill_d), .match_count(cnt_d));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]  d;
    logic [15:0] h;
    logic [11:0] f;
    logic [31:0] c;
  } exp_t;

  exp_t sb[$];

  logic [3:0] pat  [4] = '{4'b1011, 4'b1011, 4'b1011, 4'b0001};
  bit         ov   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int         cmax [4] = '{255, 255, 3, 255};
  logic [3:0] m_hist [4];
  int         m_fill [4];
  int         m_cnt  [4];
  bit         m_det  [4];

  task automatic model_step(input logic r, input logic en, input logic x, input logic clr);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] nh;
      int nf;
      bit hit;
      if (r) begin
        m_hist[i] = '0; m_fill[i] = 0; m_cnt[i] = 0; m_det[i] = 1'b0;
      end else begin
        nh  = {m_hist[i][2:0], x};
        nf  = (m_fill[i] < 4) ? m_fill[i] + 1 : 4;
        hit = en && (nh == pat[i]) && (nf == 4);
        m_det[i] = hit;
        if (en) begin
          m_hist[i] = nh;
          m_fill[i] = (hit && !ov[i]) ? 0 : nf;
        end
        if (clr) m_cnt[i] = 0;
        else if (hit && m_cnt[i] < cmax[i]) m_cnt[i]++;
      end
      e.d[i]        = m_det[i];
      e.h[i*4 +: 4] = m_hist[i];
      e.f[i*3 +: 3] = 3'(m_fill[i]);
      e.c[i*8 +: 8] = 8'(m_cnt[i]);
    end
    sb.push_back(e);
  endtask

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("a.detect", 32'(det_a),  32'(e.d[0]));
      check("a.hist",   32'(hist_a), 32'(e.h[3:0]));
      check("a.fill",   32'(fill_a), 32'(e.f[2:0]));
      check("a.count",  32'(cnt_a),  32'(e.c[7:0]));
      check("b.detect", 32'(det_b),  32'(e.d[1]));
      check("b.hist",   32'(hist_b), 32'(e.h[7:4]));
      check("b.fill",   32'(fill_b), 32'(e.f[5:3]));
      check("b.count",  32'(cnt_b),  32'(e.c[15:8]));
      check("c.detect", 32'(det_c),  32'(e.d[2]));
      check("c.hist",   32'(hist_c), 32'(e.h[11:8]));
      check("c.fill",   32'(fill_c), 32'(e.f[8:6]));
      check("c.count",  32'(cnt_c),  32'(e.c[23:16]));
      check("d.detect", 32'(det_d),  32'(e.d[3]));
      check("d.hist",   32'(hist_d), 32'(e.h[15:12]));
      check("d.fill",   32'(fill_d), 32'(e.f[11:9]));
      check("d.count",  32'(cnt_d),  32'(e.c[31:24]));
    end
  end

  task automatic step(input logic r, input logic en, input logic x, input logic clr);
    @(negedge clock);
    reset = r; x_en = en; x_in = x; cnt_clr = clr;
    model_step(r, en, x, clr);
  endtask

  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, v[i], 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; x_en = 1'b0; x_in = 1'b0; cnt_clr = 1'b0;
    do_reset(2);
    // basic match
    send(32'b1011, 4); idle(1);
    // overlap vs non-overlap
    do_reset(1); send(32'b1011011, 7); idle(1);
    do_reset(1); send(32'b10111011, 8); idle(1);
    // x_en gap with x_in held low
    do_reset(1); send(32'b10, 2); idle(3); send(32'b11, 2); idle(1);
    // saturation of the 2-bit counter, then clear racing a hit
    do_reset(1); send(32'b1011, 4);
    for (int k = 0; k < 4; k++) send(32'b011, 3);
    send(32'b01, 2); step(1'b0, 1'b1, 1'b1, 1'b1);
    send(32'b011, 3); idle(1);
    // reset mid-pattern
    do_reset(1); send(32'b101, 3); do_reset(1); send(32'b1, 1); send(32'b011, 3); idle(1);
    // partial-fill guard for PATTERN=0001
    do_reset(1); send(32'b1, 1); send(32'b0001, 4); idle(1);
    // random traffic
    for (int k = 0; k < 300; k++)
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0));
    idle(2);
    @(posedge clock); #2;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
